// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU command scheduler.
package alu_sched_pkg;

  // Scheduler FSM states, in the order a command walks through them.
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WR_A          = 3'd1,
    WR_B          = 3'd2,
    EXEC          = 3'd3,
    WAIT_VLD      = 3'd4,
    WAIT_TX_START = 3'd5,
    WAIT_TX_END   = 3'd6
  } sched_state_e;

  // RegFile locations the ALU reads its operands from.
  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  // States that wait on an external event and are therefore guarded by the timeout counter.
  function automatic logic is_wait_state(input sched_state_e s);
    return (s == WAIT_VLD) || (s == WAIT_TX_START) || (s == WAIT_TX_END);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Purely combinational: a lone request
// always wins; when both request, the one that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  // Pick at most one requester; grant is one-hot or zero.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_cmd_scheduler.sv
// Shares the RegFile -> ALU -> UART_TX result path between two command
// requesters. One command is in flight at a time: operands are written to
// RegFile addresses 0/1, the ALU is fired, and the scheduler then waits for
// the ALU result and the complete UART frame before accepting another
// command. Every wait state is bounded by a timeout that aborts the command.
module alu_cmd_scheduler #(
  parameter int WIDTH      = 8,
  parameter int ADDR       = 4,
  parameter int ALU_FUN_WD = 4,
  parameter int TMO_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  // Requester 0
  input  logic                  REQ0_VLD,
  input  logic [WIDTH-1:0]      REQ0_A,
  input  logic [WIDTH-1:0]      REQ0_B,
  input  logic [ALU_FUN_WD-1:0] REQ0_FUN,
  output logic                  REQ0_RDY,
  // Requester 1
  input  logic                  REQ1_VLD,
  input  logic [WIDTH-1:0]      REQ1_A,
  input  logic [WIDTH-1:0]      REQ1_B,
  input  logic [ALU_FUN_WD-1:0] REQ1_FUN,
  output logic                  REQ1_RDY,
  // RegFile write port
  output logic                  WrEn,
  output logic [ADDR-1:0]       Address,
  output logic [WIDTH-1:0]      WrData,
  // ALU and its clock gate
  output logic                  CLKG_EN,
  output logic                  ALU_Enable,
  output logic [ALU_FUN_WD-1:0] ALU_FUN,
  input  logic                  ALU_VLD,
  // UART transmitter status
  input  logic                  UART_Busy,
  // Status
  output logic                  GRANT_ID,
  output logic                  CMD_DONE,
  output logic                  TMO_ERR
);

  import alu_sched_pkg::*;

  // Counter value seen on the last allowed cycle of a wait state: the counter
  // reads 0 on the first cycle, so this is cycle number 2**TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_HIT_CNT = TMO_W'((2 ** TMO_W) - 2);

  sched_state_e          r_state;
  sched_state_e          w_next;
  logic                  r_last_grant;
  logic                  r_grant_id;
  logic [WIDTH-1:0]      r_op_a;
  logic [WIDTH-1:0]      r_op_b;
  logic [ALU_FUN_WD-1:0] r_fun;
  logic [TMO_W-1:0]      r_tmo_cnt;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  logic                  w_tmo_hit;
  logic                  w_done;
  logic                  w_tmo;

  // Requests are only offered to the arbiter while idle and out of reset,
  // so a VLD seen in any other cycle is simply not accepted.
  assign w_req    = {REQ1_VLD, REQ0_VLD} & {2{(r_state == IDLE) & ~RST}};
  assign w_accept = |w_gnt;
  assign REQ0_RDY = w_gnt[0];
  assign REQ1_RDY = w_gnt[1];

  rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  assign w_tmo_hit = (r_tmo_cnt == TMO_HIT_CNT);

  // A command being aborted by reset reports neither completion nor timeout.
  assign CMD_DONE = w_done & ~RST;
  assign TMO_ERR  = w_tmo & ~RST;
  assign GRANT_ID = r_grant_id;

  // Next-state and output decode. A wait state's exit event takes priority
  // over its timeout, so an event arriving on the limit cycle still counts.
  always_comb begin
    w_next     = r_state;
    WrEn       = 1'b0;
    Address    = '0;
    WrData     = '0;
    CLKG_EN    = 1'b0;
    ALU_Enable = 1'b0;
    ALU_FUN    = '0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) w_next = WR_A;
      end

      WR_A: begin
        WrEn    = 1'b1;
        Address = ADDR'(ALU_A_ADDR);
        WrData  = r_op_a;
        w_next  = WR_B;
      end

      WR_B: begin
        WrEn    = 1'b1;
        Address = ADDR'(ALU_B_ADDR);
        WrData  = r_op_b;
        w_next  = EXEC;
      end

      EXEC: begin
        CLKG_EN    = 1'b1;
        ALU_Enable = 1'b1;
        ALU_FUN    = r_fun;
        w_next     = WAIT_VLD;
      end

      WAIT_VLD: begin
        // Keep the ALU clocked with its function stable until the result lands.
        CLKG_EN = 1'b1;
        ALU_FUN = r_fun;
        if (ALU_VLD) begin
          w_next = WAIT_TX_START;
        end else if (w_tmo_hit) begin
          CLKG_EN = 1'b0;
          w_tmo   = 1'b1;
          w_next  = IDLE;
        end
      end

      WAIT_TX_START: begin
        if (UART_Busy) begin
          w_next = WAIT_TX_END;
        end else if (w_tmo_hit) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end

      WAIT_TX_END: begin
        if (!UART_Busy) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_tmo_hit) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register, grant history, operand latches and the wait-state timeout counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the operand latches are ordinary flops, not a RAM, so they are reset like every other register here.
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_fun        <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_state <= w_next;

      if (w_accept) begin
        r_last_grant <= w_gnt[1];
        r_grant_id   <= w_gnt[1];
        r_op_a       <= w_gnt[1] ? REQ1_A   : REQ0_A;
        r_op_b       <= w_gnt[1] ? REQ1_B   : REQ0_B;
        r_fun        <= w_gnt[1] ? REQ1_FUN : REQ0_FUN;
      end

      // Count only while remaining in the same wait state; any transition restarts from zero.
      if (is_wait_state(w_next) && (w_next == r_state)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule
